// File: rtl/flexible_clock_divider.sv
// Divides basys_clock by 2*(m+1): clk_out toggles each time the counter reaches m.
// Define FCD_TICK_EN to add a registered one-cycle strobe on every clk_out rising transition.
module flexible_clock_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             basys_clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] m,
`ifdef FCD_TICK_EN
  output logic             tick,
`endif
  output logic             clk_out
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             clk_out_q, clk_out_d;
  logic             wrap;

  // >= rather than == so a lowered m wraps immediately and all-ones never overflows.
  always_comb begin
    wrap      = (count_q >= m);
    count_d   = wrap ? '0 : count_q + WIDTH'(1);
    clk_out_d = wrap ? ~clk_out_q : clk_out_q;
  end

  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      clk_out_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

`ifdef FCD_TICK_EN
  logic tick_q, tick_d;

  always_comb begin
    tick_d = wrap & ~clk_out_q;
  end

  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
`endif

endmodule

// File: tb/tb_flexible_clock_divider.sv
// Randomized self-checking bench for flexible_clock_divider against an integer reference model.
// A 4-bit instance with m at all-ones exercises the terminal-count wrap at the counter maximum.
module tb_flexible_clock_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m;
  logic        clk_out, clk4;
  logic        tick_w, tick4;
  logic [3:0]  m4;

  always #5 clk = ~clk;

  flexible_clock_divider #(.WIDTH(32)) dut (
    .basys_clock (clk),
    .rst_n       (rst_n),
    .m           (m),
`ifdef FCD_TICK_EN
    .tick        (tick_w),
`endif
    .clk_out     (clk_out)
  );

  flexible_clock_divider #(.WIDTH(4)) dut_w4 (
    .basys_clock (clk),
    .rst_n       (rst_n),
    .m           (m4),
`ifdef FCD_TICK_EN
    .tick        (tick4),
`endif
    .clk_out     (clk4)
  );

`ifndef FCD_TICK_EN
  assign tick_w = 1'b0;
  assign tick4  = 1'b0;
`endif

  int     num_cmp = 0;
  int     num_err = 0;
  longint ref_cnt, ref4_cnt;
  bit     ref_clk, ref_tick, ref4_clk, ref4_tick;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_cmp++;
    if (got !== exp) begin
      num_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ref_cnt  = 0; ref_clk  = 0; ref_tick  = 0;
    ref4_cnt = 0; ref4_clk = 0; ref4_tick = 0;
  endtask

  // Half-period rule: count up to m, then restart at zero and flip the output.
  task automatic model_edge(input longint mm, inout longint c, inout bit k, inout bit t);
    if (c >= mm) begin
      c = 0;
      k = ~k;
      t = k;
    end else begin
      c = c + 1;
      t = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      model_edge({32'b0, m}, ref_cnt, ref_clk, ref_tick);
      model_edge({60'b0, m4}, ref4_cnt, ref4_clk, ref4_tick);
    end else begin
      model_reset();
    end
    #1;
    check_eq("clk_out", {63'b0, clk_out}, {63'b0, ref_clk});
    check_eq("clk_out_w4", {63'b0, clk4}, {63'b0, ref4_clk});
`ifdef FCD_TICK_EN
    check_eq("tick", {63'b0, tick_w}, {63'b0, ref_tick});
    check_eq("tick_w4", {63'b0, tick4}, {63'b0, ref4_tick});
`endif
  endtask

  // Assert reset between edges, confirm the outputs clear at once, hold for one edge, release.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_clk_out", {63'b0, clk_out}, 64'd0);
    check_eq("rst_clk_out_w4", {63'b0, clk4}, 64'd0);
`ifdef FCD_TICK_EN
    check_eq("rst_tick", {63'b0, tick_w}, 64'd0);
`endif
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  // Number of edges until clk_out reaches lvl (bounded).
  task automatic wait_level(input bit lvl, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (clk_out !== lvl && n < limit);
  endtask

  int         n;
  logic [3:0] pat;

  initial begin
    m     = 32'd0;
    m4    = 4'hF;
    rst_n = 1'b1;
    model_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("init_clk_out", {63'b0, clk_out}, 64'd0);
    check_eq("init_tick", {63'b0, tick_w}, 64'd0);
    step();
    rst_n = 1'b1;

    // m = 0: output runs at half the input clock, starting high.
    pat = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("m0_seq", {63'b0, clk_out}, {63'b0, pat[i]});
    end

    // m = 3: rises at edge 4, falls at 8, rises at 12.
    m = 32'd3;
    do_reset();
    wait_level(1'b1, 50, n);
    check_eq("m3_first_rise", n, 64'd4);
    wait_level(1'b0, 50, n);
    check_eq("m3_fall", n, 64'd4);
    wait_level(1'b1, 50, n);
    check_eq("m3_second_rise", n, 64'd4);

    // m = 10, lowered to 2 at count 7: immediate wrap, then 3-cycle halves.
    m = 32'd10;
    do_reset();
    for (int i = 0; i < 7; i++) step();
    m = 32'd2;
    wait_level(1'b1, 50, n);
    check_eq("m_drop_wrap", n, 64'd1);
    wait_level(1'b0, 50, n);
    check_eq("m_drop_half1", n, 64'd3);
    wait_level(1'b1, 50, n);
    check_eq("m_drop_half2", n, 64'd3);

    // m = 5, reset mid high phase, restart from zero.
    m = 32'd5;
    do_reset();
    wait_level(1'b1, 50, n);
    check_eq("m5_rise", n, 64'd6);
    step();
    step();
    do_reset();
    wait_level(1'b1, 50, n);
    check_eq("m5_rise_after_rst", n, 64'd6);

    // All-ones terminal count on the 4-bit instance.
    do_reset();
    for (int i = 0; i < 16; i++) step();
    check_eq("w4_allones_rise", {63'b0, clk4}, 64'd1);
    for (int i = 0; i < 16; i++) step();
    check_eq("w4_allones_fall", {63'b0, clk4}, 64'd0);

    // Randomized m changes and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 16 == 0) m = 32'($urandom_range(0, 12));
      if ($urandom % 300 == 0) do_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_cmp, num_err);
    $finish;
  end

endmodule
